// File: rtl/agu_pipe_if.sv
// -----------------------------------------------------------------------------
// agu_pipe_if
//   Bundles the segment-write port, the request channel and the result
//   channel of the segment:offset address generation unit.
//
//   Signals (direction seen from the AGU, i.e. the slave modport):
//     seg_we, seg_wsel, seg_wdata      in   segment register write port
//     req_valid, req_ready             in/out request handshake
//     req_seg, req_base, req_index,
//     req_disp, req_mode               in   request payload
//     out_valid, out_ready             out/in result handshake
//     out_addr, out_offset,
//     out_ea_ovf, out_pa_ovf           out  result payload
//
//   Modports:
//     master  decode/execute side plus bus-interface side (the bench)
//     slave   the AGU itself
// -----------------------------------------------------------------------------
interface agu_pipe_if #(
  parameter int OFFSET_W  = 16,
  parameter int ADDR_W    = 20,
  parameter int SEG_IDX_W = 2
);

  logic                 seg_we;
  logic [SEG_IDX_W-1:0] seg_wsel;
  logic [OFFSET_W-1:0]  seg_wdata;

  logic                 req_valid;
  logic                 req_ready;
  logic [SEG_IDX_W-1:0] req_seg;
  logic [OFFSET_W-1:0]  req_base;
  logic [OFFSET_W-1:0]  req_index;
  logic [OFFSET_W-1:0]  req_disp;
  logic [1:0]           req_mode;

  logic                 out_valid;
  logic                 out_ready;
  logic [ADDR_W-1:0]    out_addr;
  logic [OFFSET_W-1:0]  out_offset;
  logic                 out_ea_ovf;
  logic                 out_pa_ovf;

  modport master (
    output seg_we, seg_wsel, seg_wdata,
    output req_valid, req_seg, req_base, req_index, req_disp, req_mode,
    input  req_ready,
    input  out_valid, out_addr, out_offset, out_ea_ovf, out_pa_ovf,
    output out_ready
  );

  modport slave (
    input  seg_we, seg_wsel, seg_wdata,
    input  req_valid, req_seg, req_base, req_index, req_disp, req_mode,
    output req_ready,
    output out_valid, out_addr, out_offset, out_ea_ovf, out_pa_ovf,
    input  out_ready
  );

endinterface

// File: rtl/agu_pipe.sv
// -----------------------------------------------------------------------------
// agu_pipe
//   Two-stage pipelined segment:offset address generation unit.
//     Stage 1: offset = base [+ index] [+ disp], with offset-overflow flag,
//              and capture of the selected segment register.
//     Stage 2: address = (segment << SEG_SHIFT) + offset, with address-
//              overflow flag. Stage 2 registers drive the result channel.
//   Valid/ready on both sides, one request per cycle, order preserved.
//
//   Ports:
//     clk      in  rising-edge clock
//     rst_n    in  asynchronous active-low reset
//     io_bus   agu_pipe_if.slave (segment write, request, result channels)
// -----------------------------------------------------------------------------
module agu_pipe #(
  parameter int OFFSET_W  = 16,
  parameter int SEG_SHIFT = 4,
  parameter int ADDR_W    = 20,
  parameter int NUM_SEG   = 4,
  parameter int SEG_IDX_W = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  agu_pipe_if.slave io_bus
);

  localparam int EA_W    = OFFSET_W + 2;
  localparam int SHIFT_W = OFFSET_W + SEG_SHIFT;
  // Wide enough to hold the shifted segment plus one carry bit, so any bit
  // at or above ADDR_W means the physical address wrapped.
  localparam int SUM_W   = ((SHIFT_W > ADDR_W) ? SHIFT_W : ADDR_W) + 1;
  localparam logic [SEG_IDX_W:0] NUM_SEG_L = (SEG_IDX_W + 1)'(NUM_SEG);

  // Segment register file
  logic [OFFSET_W-1:0] r_seg [NUM_SEG];

  // Stage 1
  logic                r_s1_valid;
  logic [OFFSET_W-1:0] r_s1_offset;
  logic                r_s1_ea_ovf;
  logic [OFFSET_W-1:0] r_s1_seg;

  // Stage 2 (result channel)
  logic                r_s2_valid;
  logic [ADDR_W-1:0]   r_s2_addr;
  logic [OFFSET_W-1:0] r_s2_offset;
  logic                r_s2_ea_ovf;
  logic                r_s2_pa_ovf;

  logic                w_s2_free;
  logic                w_req_ready;
  logic                w_req_fire;
  logic                w_seg_wr;
  logic                w_req_seg_ok;
  logic [OFFSET_W-1:0] w_seg_rd;
  logic [EA_W-1:0]     w_ea_sum;
  logic [SUM_W-1:0]    w_pa_sum;

  // Stage 2 can take new data when empty or being drained this cycle;
  // stage 1 likewise when empty or moving into stage 2. Neither term looks
  // at req_valid, so ready never depends combinationally on valid.
  assign w_s2_free   = !r_s2_valid || io_bus.out_ready;
  assign w_req_ready = !r_s1_valid || w_s2_free;
  assign w_req_fire  = io_bus.req_valid && w_req_ready;

  assign w_seg_wr     = io_bus.seg_we && ({1'b0, io_bus.seg_wsel} < NUM_SEG_L);
  assign w_req_seg_ok = {1'b0, io_bus.req_seg} < NUM_SEG_L;

  // Segment read with write-through forwarding: a write landing on the same
  // edge as the accept is what the request sees.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch can never be inferred.
    w_seg_rd = '0;
    if (w_req_seg_ok) begin
      if (w_seg_wr && (io_bus.seg_wsel == io_bus.req_seg)) begin
        w_seg_rd = io_bus.seg_wdata;
      end else begin
        w_seg_rd = r_seg[io_bus.req_seg];
      end
    end
  end

  assign w_ea_sum = EA_W'(io_bus.req_base)
                  + (io_bus.req_mode[0] ? EA_W'(io_bus.req_index) : '0)
                  + (io_bus.req_mode[1] ? EA_W'(io_bus.req_disp)  : '0);

  assign w_pa_sum = (SUM_W'(r_s1_seg) << SEG_SHIFT) + SUM_W'(r_s1_offset);

  // Segment registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the segment file is architecturally visible state (reads of an
      // unwritten segment must return 0), so unlike a data buffer it is reset.
      for (int i = 0; i < NUM_SEG; i++) begin
        r_seg[i] <= '0;
      end
    end else if (w_seg_wr) begin
      r_seg[io_bus.seg_wsel] <= io_bus.seg_wdata;
    end
  end

  // Stage 1: effective offset and segment capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_s1_valid  <= 1'b0;
      r_s1_offset <= '0;
      r_s1_ea_ovf <= 1'b0;
      r_s1_seg    <= '0;
    end else begin
      if (w_req_ready) begin
        r_s1_valid <= io_bus.req_valid;
      end
      if (w_req_fire) begin
        r_s1_offset <= w_ea_sum[OFFSET_W-1:0];
        r_s1_ea_ovf <= |w_ea_sum[EA_W-1:OFFSET_W];
        r_s1_seg    <= w_seg_rd;
      end
    end
  end

  // Stage 2: physical address; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_addr   <= '0;
      r_s2_offset <= '0;
      r_s2_ea_ovf <= 1'b0;
      r_s2_pa_ovf <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_addr   <= w_pa_sum[ADDR_W-1:0];
        r_s2_offset <= r_s1_offset;
        r_s2_ea_ovf <= r_s1_ea_ovf;
        r_s2_pa_ovf <= |w_pa_sum[SUM_W-1:ADDR_W];
      end
    end
  end

  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.out_valid  = r_s2_valid;
  assign io_bus.out_addr   = r_s2_addr;
  assign io_bus.out_offset = r_s2_offset;
  assign io_bus.out_ea_ovf = r_s2_ea_ovf;
  assign io_bus.out_pa_ovf = r_s2_pa_ovf;

endmodule

// File: tb/tb_agu_pipe.sv
// -----------------------------------------------------------------------------
// tb_agu_pipe
//   Self-checking bench for agu_pipe. Inputs change on the falling edge;
//   handshakes are evaluated 1 ns later, before the rising edge that acts on
//   them. Accepted requests push a model-computed result into a queue; every
//   cycle with out_valid compares the DUT result against the queue head,
//   which is popped when the result is consumed.
// -----------------------------------------------------------------------------
module tb_agu_pipe;

  localparam int OFFSET_W  = 16;
  localparam int ADDR_W    = 20;
  localparam int SEG_IDX_W = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] offset;
    logic        ea_ovf;
    logic        pa_ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  agu_pipe_if #(.OFFSET_W(OFFSET_W), .ADDR_W(ADDR_W), .SEG_IDX_W(SEG_IDX_W)) bus ();

  agu_pipe #(
    .OFFSET_W (OFFSET_W),
    .SEG_SHIFT(4),
    .ADDR_W   (ADDR_W),
    .NUM_SEG  (4),
    .SEG_IDX_W(SEG_IDX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];
  int unsigned m_seg[4];
  logic        acc;
  logic        hold_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned seg, input int unsigned base,
                                 input int unsigned idx, input int unsigned disp,
                                 input logic [1:0] mode);
    exp_t        e;
    int unsigned ea;
    int unsigned pa;
    ea = base + (mode[0] ? idx : 0) + (mode[1] ? disp : 0);
    e.offset = ea % 32'h10000;
    e.ea_ovf = (ea > 32'hFFFF);
    pa = seg * 16 + e.offset;
    e.addr   = pa % 32'h100000;
    e.pa_ovf = (pa > 32'hFFFFF);
    return e;
  endfunction

  // One cycle: called at a falling edge with inputs already driven.
  task automatic tick();
    exp_t        e;
    int unsigned segv;
    #1;
    acc = 1'b0;
    if (hold_prev) check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
    if (bus.out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb_q[0];
        check("out_addr",   {12'b0, bus.out_addr},   e.addr);
        check("out_offset", {16'b0, bus.out_offset}, e.offset);
        check("out_ea_ovf", {31'b0, bus.out_ea_ovf}, {31'b0, e.ea_ovf});
        check("out_pa_ovf", {31'b0, bus.out_pa_ovf}, {31'b0, e.pa_ovf});
        if (bus.out_ready) void'(sb_q.pop_front());
      end
    end
    if (bus.req_valid && bus.req_ready) begin
      segv = (bus.seg_we && bus.seg_wsel == bus.req_seg) ? bus.seg_wdata : m_seg[bus.req_seg];
      sb_q.push_back(model(segv, bus.req_base, bus.req_index, bus.req_disp, bus.req_mode));
      acc = 1'b1;
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    if (bus.seg_we) m_seg[bus.seg_wsel] = bus.seg_wdata;
    @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] seg, input logic [15:0] base,
                         input logic [15:0] idx, input logic [15:0] disp,
                         input logic [1:0] mode);
    bus.req_valid = 1'b1;
    bus.req_seg   = seg;
    bus.req_base  = base;
    bus.req_index = idx;
    bus.req_disp  = disp;
    bus.req_mode  = mode;
  endtask

  // Hold a request until accepted, bounded.
  task automatic send(input logic [1:0] seg, input logic [15:0] base,
                      input logic [15:0] idx, input logic [15:0] disp,
                      input logic [1:0] mode);
    set_req(seg, base, idx, disp, mode);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) break;
    end
    check("send_accepted", {31'b0, acc}, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic seg_write(input logic [1:0] sel, input logic [15:0] data);
    bus.seg_we    = 1'b1;
    bus.seg_wsel  = sel;
    bus.seg_wdata = data;
    tick();
    bus.seg_we = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check("drain_empty", sb_q.size(), 32'd0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_out_addr",  {12'b0, bus.out_addr},  32'd0);
    check("rst_out_offset",{16'b0, bus.out_offset},32'd0);
    check("rst_flags", {30'b0, bus.out_ea_ovf, bus.out_pa_ovf}, 32'd0);
    sb_q.delete();
    foreach (m_seg[i]) m_seg[i] = 0;
    hold_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.seg_we    = 1'b0;
    bus.seg_wsel  = '0;
    bus.seg_wdata = '0;
    bus.req_valid = 1'b0;
    bus.req_seg   = '0;
    bus.req_base  = '0;
    bus.req_index = '0;
    bus.req_disp  = '0;
    bus.req_mode  = '0;
    bus.out_ready = 1'b1;
    hold_prev     = 1'b0;
    acc           = 1'b0;
    @(negedge clk);
    do_reset();

    // T1: basic address, plus two-edge latency
    seg_write(2'd3, 16'h1234);
    send(2'd3, 16'h0010, 16'h0000, 16'h0000, 2'b00);
    check("t1_lat_edge1", {31'b0, bus.out_valid}, 32'd0);
    tick();
    check("t1_lat_edge2", {31'b0, bus.out_valid}, 32'd1);
    drain();

    // T2: physical address wraps
    seg_write(2'd1, 16'hFFFF);
    send(2'd1, 16'h0010, 16'h0000, 16'h0000, 2'b00);
    drain();

    // T3: offset wraps, index added
    send(2'd0, 16'hFFF0, 16'h0020, 16'h0000, 2'b01);
    drain();

    // T4: backpressure, third request refused, outputs held, order kept
    bus.out_ready = 1'b0;
    send(2'd3, 16'h0001, 16'h0000, 16'h0000, 2'b00);
    send(2'd1, 16'h0002, 16'h0000, 16'h0000, 2'b00);
    set_req(2'd0, 16'h0003, 16'h0000, 16'h0000, 2'b00);
    tick();
    check("t4_ready_low", {31'b0, acc}, 32'd0);
    repeat (3) tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc) break;
    end
    check("t4_third_accepted", {31'b0, acc}, 32'd1);
    bus.req_valid = 1'b0;
    drain();

    // T5: forwarding on same index, independent write on another index,
    // segment write while request is in flight, all three components.
    bus.seg_we    = 1'b1;
    bus.seg_wsel  = 2'd2;
    bus.seg_wdata = 16'hA000;
    send(2'd2, 16'h0005, 16'h0000, 16'h0000, 2'b00);
    bus.seg_wsel  = 2'd0;
    bus.seg_wdata = 16'h0777;
    send(2'd2, 16'h1000, 16'h0200, 16'h0030, 2'b11);
    bus.seg_wsel  = 2'd2;
    bus.seg_wdata = 16'h5555;
    tick();
    bus.seg_we = 1'b0;
    send(2'd0, 16'hF000, 16'h0F00, 16'h0100, 2'b10);
    drain();

    // Randomised traffic with random backpressure and segment writes
    for (int i = 0; i < 80; i++) begin
      bus.req_valid = ($urandom_range(0, 2) != 0);
      bus.req_seg   = 2'($urandom_range(0, 3));
      bus.req_base  = 16'($urandom);
      bus.req_index = 16'($urandom);
      bus.req_disp  = 16'($urandom);
      bus.req_mode  = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.seg_we    = ($urandom_range(0, 3) == 0);
      bus.seg_wsel  = 2'($urandom_range(0, 3));
      bus.seg_wdata = 16'($urandom);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.seg_we    = 1'b0;
    drain();

    // T6: reset with two requests in flight
    seg_write(2'd3, 16'h4321);
    bus.out_ready = 1'b0;
    send(2'd3, 16'h0100, 16'h0000, 16'h0000, 2'b00);
    send(2'd3, 16'h0200, 16'h0000, 16'h0000, 2'b00);
    do_reset();
    bus.out_ready = 1'b1;
    send(2'd3, 16'h0022, 16'h0000, 16'h0000, 2'b00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
